uart_rx_fifo: RTL

Parametrised UART receiver, successor to the fixed-format receiver inside top_uart.
- Integrated baud-tick generator.
- Configurable data width, parity and stop bits.
- 3-sample majority vote per bit; parity, framing and break detection.
- Small output FIFO with valid/ready handshake, so the consumer (interface FSM) may stall without losing frames.

---
 rtl/uart_rx_fifo.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receiver with majority-vote sampling, error detection and FWFT output FIFO
module uart_rx_fifo #(
    parameter int  N_BITS     = 8,
    parameter int  PARITY     = 0,
    parameter int  STOP_BITS  = 1,
    parameter int  SAMPLING   = 16,
    parameter real F_CLOCK    = 50.0e6,
    parameter int  BAUDRATE   = 9600,
    parameter int  FIFO_DEPTH = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_rx,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [N_BITS-1:0] o_data,
    output logic              o_parity_err,
    output logic              o_frame_err,
    output logic              o_rx_done,
    output logic              o_overrun,
    output logic              o_busy
);
    localparam int DIV_R = $rtoi(F_CLOCK / (real'(BAUDRATE) * real'(SAMPLING)) + 0.5);
    localparam int DIV   = (DIV_R < 1) ? 1 : DIV_R;
    localparam int TW    = $clog2(DIV + 1);
    localparam int SW    = $clog2(SAMPLING);
    localparam int BW    = $clog2(N_BITS + 1);
    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int CW    = PW + 1;
    localparam int EW    = N_BITS + 2;
    localparam int H     = SAMPLING / 2;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRK_WAIT} state_t;

    logic [TW-1:0] tick_cnt_q;
    logic          tick;
    logic          rx_meta_q, rx_q;

    assign tick = (tick_cnt_q == TW'(DIV - 1));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            tick_cnt_q <= '0;
            rx_meta_q  <= 1'b1;
            rx_q       <= 1'b1;
        end else begin
            tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
            rx_meta_q  <= i_rx;
            rx_q       <= rx_meta_q;
        end
    end

    state_t            state_q;
    logic [SW-1:0]     s_q;
    logic [BW-1:0]     bit_q;
    logic [1:0]        smp_q;
    logic [N_BITS-1:0] data_q;
    logic              par_err_q, frm_err_q;
    logic              rx_done_q, push_q;
    logic [EW-1:0]     push_data_q;
    logic              maj, end_bit, mid_bit, par_bad;

    // Third sample is taken live; the vote is used on that same tick.
    assign maj     = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_q) | (smp_q[1] & rx_q);
    assign end_bit = (s_q == SW'(SAMPLING - 1));
    assign mid_bit = (s_q == SW'(H + 1));
    assign par_bad = (^data_q) ^ maj ^ (PARITY == 1);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= S_IDLE;
            s_q         <= '0;
            bit_q       <= '0;
            smp_q       <= 2'b11;
            data_q      <= '0;
            par_err_q   <= 1'b0;
            frm_err_q   <= 1'b0;
            rx_done_q   <= 1'b0;
            push_q      <= 1'b0;
            push_data_q <= '0;
        end else begin
            rx_done_q <= 1'b0;
            push_q    <= 1'b0;
            case (state_q)
                S_IDLE: if (!rx_q) begin
                    state_q   <= S_START;
                    s_q       <= '0;
                    bit_q     <= '0;
                    par_err_q <= 1'b0;
                    frm_err_q <= 1'b0;
                end
                S_BRK_WAIT: if (rx_q) state_q <= S_IDLE;
                default: if (tick) begin
                    s_q <= end_bit ? '0 : s_q + 1'b1;
                    if (s_q == SW'(H - 1)) smp_q[0] <= rx_q;
                    if (s_q == SW'(H))     smp_q[1] <= rx_q;
                    if (mid_bit) begin
                        case (state_q)
                            S_START:  if (maj) state_q <= S_IDLE;
                            S_DATA:   data_q <= (data_q >> 1) | (N_BITS'(maj) << (N_BITS - 1));
                            S_PARITY: par_err_q <= par_bad;
                            S_STOP: begin
                                frm_err_q <= frm_err_q | ~maj;
                                if (bit_q == BW'(STOP_BITS - 1)) begin
                                    rx_done_q   <= 1'b1;
                                    push_q      <= 1'b1;
                                    push_data_q <= {data_q, par_err_q, frm_err_q | ~maj};
                                    state_q     <= (data_q == '0 && !maj) ? S_BRK_WAIT : S_IDLE;
                                end
                            end
                            default: ;
                        endcase
                    end
                    if (end_bit) begin
                        case (state_q)
                            S_START: begin
                                state_q <= S_DATA;
                                bit_q   <= '0;
                            end
                            S_DATA: begin
                                if (bit_q == BW'(N_BITS - 1)) begin
                                    state_q <= (PARITY != 0) ? S_PARITY : S_STOP;
                                    bit_q   <= '0;
                                end else begin
                                    bit_q <= bit_q + 1'b1;
                                end
                            end
                            S_PARITY: begin
                                state_q <= S_STOP;
                                bit_q   <= '0;
                            end
                            S_STOP: bit_q <= bit_q + 1'b1;
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic [EW-1:0] head_q, head_d;
    logic          pop, full, push_ok;

    assign pop     = i_ready & o_valid;
    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign push_ok = push_q & (~full | pop);
    assign count_d = count_q + CW'(push_ok) - CW'(pop);

    // Head is registered so it holds its last value once the FIFO drains.
    always_comb begin
        head_d = head_q;
        if (pop && count_q > CW'(1))
            head_d = mem_q[PW'(rd_ptr_q + 1'b1)];
        else if (push_ok && (count_q == '0 || (pop && count_q == CW'(1))))
            head_d = push_data_q;
    end

    always_ff @(posedge i_clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data_q;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            head_q  <= head_d;
        end
    end

    assign o_valid                            = (count_q != '0);
    assign {o_data, o_parity_err, o_frame_err} = head_q;
    assign o_rx_done                          = rx_done_q;
    assign o_overrun                          = push_q & ~push_ok;
    assign o_busy                             = (state_q != S_IDLE);
endmodule
